mem_bus_arbiter: RTL and testbench

// Shares the single-port Memory between two bus masters: M0 = Processor, M1 = loader/DMA port (UART boot loader).

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/mem_arb_slot.sv | 96 +++++++++
 rtl/mem_bus_arbiter.sv | 81 ++++++++
 tb/tb_mem_bus_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the two-master memory bus arbiter
//   slot_e   - per-master pending slot state (FREE / PEND / RDATA)
//   master_e - master ids used by the round-robin pointer
package mem_bus_pkg;
    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_RDATA = 2'd2
    } slot_e;
    typedef enum logic {
        M_CPU = 1'b0,
        M_DMA = 1'b1
    } master_e;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one master's pending-access slot, slot FSM and registered read data
//   clk, reset       - clock, synchronous active-low reset
//   addr_i..rstrb_i  - master strobe inputs, captured only while the slot is FREE
//   grant_i          - slot is issued to memory this cycle
//   mem_rdata_i      - memory read data, captured in the RDATA cycle
//   pend_o           - slot holds an access waiting for issue
//   rd_o, addr_o, wdata_o, wmask_o - captured access
//   rdata_o, rbusy_o, wbusy_o      - master-facing read data and busy flags
//   overrun_o        - strobe arrived while the slot was occupied (one-cycle pulse)
module mem_arb_slot
    import mem_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wmask_i,
    input  logic            rstrb_i,
    input  logic            grant_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            pend_o,
    output logic            rd_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o,
    output logic [DW/8-1:0] wmask_o,
    output logic [DW-1:0]   rdata_o,
    output logic            rbusy_o,
    output logic            wbusy_o,
    output logic            overrun_o
);
    slot_e           state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DW/8-1:0] wmask_q, wmask_d;
    logic            rd_q, rd_d, rbusy_q, rbusy_d, wbusy_q, wbusy_d, stb;

    always_comb begin
        stb     = (|wmask_i) || rstrb_i;
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        if (state_q == SLOT_FREE && stb) begin
            state_d = SLOT_PEND;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            wmask_d = wmask_i;
            // a write strobe takes precedence over a simultaneous read strobe
            rd_d    = ~|wmask_i;
        end else if (state_q == SLOT_PEND && grant_i) begin
            state_d = rd_q ? SLOT_RDATA : SLOT_FREE;
        end else if (state_q == SLOT_RDATA) begin
            state_d = SLOT_FREE;
            rdata_d = mem_rdata_i;
        end
        rbusy_d = rd_d && state_d != SLOT_FREE;
        wbusy_d = !rd_d && state_d == SLOT_PEND;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SLOT_FREE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
            wbusy_q <= wbusy_d;
        end
    end

    assign pend_o    = state_q == SLOT_PEND;
    assign overrun_o = stb && state_q != SLOT_FREE;
    assign rd_o      = rd_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign wmask_o   = wmask_q;
    assign rdata_o   = rdata_q;
    assign rbusy_o   = rbusy_q;
    assign wbusy_o   = wbusy_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares single-port memory between M0 (processor) and M1 (loader/DMA)
//   clk, reset                 - clock, synchronous active-low reset
//   m?_addr/wdata/wmask/rstrb  - master strobes (nonzero wmask = write, rstrb = read)
//   m?_rdata, m?_rbusy, m?_wbusy - registered read data and outstanding flags
//   mem_addr/wdata/wmask/rstrb - access issued to memory this cycle (zero when idle)
//   mem_rdata                  - memory read data, one cycle after mem_rstrb
//   err_overrun                - sticky: a master strobed while its slot was occupied
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter bit RR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    input  logic            m0_rstrb,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rbusy,
    output logic            m0_wbusy,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    input  logic            m1_rstrb,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rbusy,
    output logic            m1_wbusy,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    output logic            mem_rstrb,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err_overrun
);
    logic            pend0, pend1, rd0, rd1, gnt0, gnt1, ov0, ov1, err_q, err_d;
    logic [AW-1:0]   a0, a1;
    logic [DW-1:0]   wd0, wd1;
    logic [DW/8-1:0] wm0, wm1;
    master_e         last_q, last_d;

    mem_arb_slot #(.AW(AW), .DW(DW)) u_s0 (
        .clk(clk), .reset(reset), .addr_i(m0_addr), .wdata_i(m0_wdata), .wmask_i(m0_wmask),
        .rstrb_i(m0_rstrb), .grant_i(gnt0), .mem_rdata_i(mem_rdata), .pend_o(pend0), .rd_o(rd0),
        .addr_o(a0), .wdata_o(wd0), .wmask_o(wm0), .rdata_o(m0_rdata), .rbusy_o(m0_rbusy),
        .wbusy_o(m0_wbusy), .overrun_o(ov0)
    );

    mem_arb_slot #(.AW(AW), .DW(DW)) u_s1 (
        .clk(clk), .reset(reset), .addr_i(m1_addr), .wdata_i(m1_wdata), .wmask_i(m1_wmask),
        .rstrb_i(m1_rstrb), .grant_i(gnt1), .mem_rdata_i(mem_rdata), .pend_o(pend1), .rd_o(rd1),
        .addr_o(a1), .wdata_o(wd1), .wmask_o(wm1), .rdata_o(m1_rdata), .rbusy_o(m1_rbusy),
        .wbusy_o(m1_wbusy), .overrun_o(ov1)
    );

    // the pointer only moves on a tie, so back-to-back ties alternate winners
    always_comb begin
        gnt1      = pend1 && (!pend0 || (RR && last_q == M_CPU));
        gnt0      = pend0 && !gnt1;
        last_d    = (RR && pend0 && pend1) ? (gnt1 ? M_DMA : M_CPU) : last_q;
        err_d     = err_q || ov0 || ov1;
        mem_addr  = gnt1 ? a1 : gnt0 ? a0 : '0;
        mem_wdata = gnt1 ? wd1 : gnt0 ? wd0 : '0;
        mem_wmask = gnt1 ? wm1 : gnt0 ? wm0 : '0;
        mem_rstrb = (gnt0 && rd0) || (gnt1 && rd1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= M_DMA;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    assign err_overrun = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, mem_rstrb, err_overrun;
    logic [3:0]  mem_wmask;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_m0_rbusy, f_m0_wbusy, f_m1_rbusy, f_m1_wbusy, f_mem_rstrb, f_err;
    logic [3:0]  f_mem_wmask;
    logic [31:0] zero_rdata;
    logic [31:0] mem [0:63];
    int n_cmp = 0, n_err = 0;

    assign zero_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .RR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata), .err_overrun(err_overrun)
    );

    mem_bus_arbiter #(.AW(32), .DW(32), .RR(1'b0)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(f_m0_rdata), .m0_rbusy(f_m0_rbusy), .m0_wbusy(f_m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(f_m1_rdata), .m1_rbusy(f_m1_rbusy), .m1_wbusy(f_m1_wbusy),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask), .mem_rstrb(f_mem_rstrb),
        .mem_rdata(zero_rdata), .err_overrun(f_err)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        m0_wmask = '0; m0_rstrb = 1'b0; m1_wmask = '0; m1_rstrb = 1'b0;
    endtask

    initial begin
        tick(); tick(); tick();
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m0_rbusy", {31'd0, m0_rbusy}, 0);
        chk("rst_m0_wbusy", {31'd0, m0_wbusy}, 0);
        chk("rst_mem_rstrb", {31'd0, mem_rstrb}, 0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_err", {31'd0, err_overrun}, 0);
        reset = 1'b1;
        tick();
        // write 0x10 <- DEADBEEF, then read it back
        m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_wmask = 4'hF;
        tick(); idle();
        chk("wr_mem_wmask", {28'd0, mem_wmask}, 32'hF);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_wbusy_t1", {31'd0, m0_wbusy}, 1);
        tick();
        chk("wr_wbusy_t2", {31'd0, m0_wbusy}, 0);
        m0_rstrb = 1'b1;
        tick(); idle();
        chk("rd_mem_rstrb_t1", {31'd0, mem_rstrb}, 1);
        chk("rd_rbusy_t1", {31'd0, m0_rbusy}, 1);
        tick();
        chk("rd_rbusy_t2", {31'd0, m0_rbusy}, 1);
        chk("rd_mem_rstrb_t2", {31'd0, mem_rstrb}, 0);
        tick();
        chk("rd_rdata_t3", m0_rdata, 32'hDEADBEEF);
        chk("rd_rbusy_t3", {31'd0, m0_rbusy}, 0);
        // byte-lane write merge
        m0_addr = 32'h20; m0_wdata = 32'h11223344; m0_wmask = 4'hF;
        tick(); idle(); tick();
        m0_wdata = 32'h0000AB00; m0_wmask = 4'b0010;
        tick(); idle();
        chk("bw_mem_wmask", {28'd0, mem_wmask}, 32'h2);
        tick();
        m0_rstrb = 1'b1;
        tick(); idle(); tick(); tick();
        chk("bw_rdata", m0_rdata, 32'h1122AB44);
        // M1 writes 0x30 so its reads are distinguishable
        m1_addr = 32'h30; m1_wdata = 32'hA5A50001; m1_wmask = 4'hF;
        tick(); idle();
        chk("m1_wr_addr", mem_addr, 32'h30);
        chk("m1_wbusy", {31'd0, m1_wbusy}, 1);
        tick();
        // simultaneous reads: first tie since reset goes to M0
        m0_addr = 32'h10; m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        tick(); idle();
        chk("tie_t1_addr", mem_addr, 32'h10);
        chk("tie_t1_rstrb", {31'd0, mem_rstrb}, 1);
        tick();
        chk("tie_t2_addr", mem_addr, 32'h30);
        chk("tie_t2_rstrb", {31'd0, mem_rstrb}, 1);
        chk("tie_t2_m1_rbusy", {31'd0, m1_rbusy}, 1);
        tick();
        chk("tie_t3_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("tie_t3_m0_rbusy", {31'd0, m0_rbusy}, 0);
        chk("tie_t3_m1_rbusy", {31'd0, m1_rbusy}, 1);
        tick();
        chk("tie_t4_m1_rdata", m1_rdata, 32'hA5A50001);
        chk("tie_t4_m1_rbusy", {31'd0, m1_rbusy}, 0);
        // repeated ties: round-robin alternates M1, M0, M1; fixed priority always M0
        m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        tick(); idle();
        chk("rr1_addr", mem_addr, 32'h30);
        chk("fp1_addr", f_mem_addr, 32'h10);
        tick(); tick(); tick();
        m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        tick(); idle();
        chk("rr2_addr", mem_addr, 32'h10);
        chk("fp2_addr", f_mem_addr, 32'h10);
        tick(); tick(); tick();
        m0_rstrb = 1'b1; m1_rstrb = 1'b1;
        tick(); idle();
        chk("rr3_addr", mem_addr, 32'h30);
        chk("fp3_addr", f_mem_addr, 32'h10);
        tick(); tick(); tick();
        chk("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rr_err", {31'd0, err_overrun}, 0);
        // overrun: M1 re-strobes while its read is outstanding
        m1_addr = 32'h30; m1_rstrb = 1'b1;
        tick();
        chk("ov_rbusy_t1", {31'd0, m1_rbusy}, 1);
        chk("ov_err_t1", {31'd0, err_overrun}, 0);
        m1_addr = 32'h10;
        tick(); idle();
        chk("ov_err_t2", {31'd0, err_overrun}, 1);
        chk("ov_mem_rstrb_t2", {31'd0, mem_rstrb}, 0);
        tick();
        chk("ov_rdata_t3", m1_rdata, 32'hA5A50001);
        chk("ov_rbusy_t3", {31'd0, m1_rbusy}, 0);
        tick();
        chk("ov_dropped_t4", {31'd0, mem_rstrb}, 0);
        chk("ov_err_sticky", {31'd0, err_overrun}, 1);
        // reset in the middle of a read
        m0_addr = 32'h20; m0_rstrb = 1'b1;
        tick(); idle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_m0_rbusy", {31'd0, m0_rbusy}, 0);
            chk("mr_mem_rstrb", {31'd0, mem_rstrb}, 0);
        end
        chk("mr_m0_rdata", m0_rdata, 0);
        chk("mr_m1_rdata", m1_rdata, 0);
        chk("mr_mem_addr", mem_addr, 0);
        chk("mr_mem_wdata", mem_wdata, 0);
        chk("mr_err", {31'd0, err_overrun}, 0);
        reset = 1'b1;
        tick();
        m0_addr = 32'h10; m0_rstrb = 1'b1;
        tick(); idle();
        chk("mr_fresh_addr", mem_addr, 32'h10);
        tick(); tick();
        chk("mr_fresh_rdata", m0_rdata, 32'hDEADBEEF);
        chk("mr_fresh_rbusy", {31'd0, m0_rbusy}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
